parity_frame_checker: RTL

//   Serial receive-side controller for the parity checker.
//   - Frames a bit stream: start(0), DATA_W data bits LSB first, parity bit, stop(1).
//   - Accumulates the running XOR over data + parity and checks it against even/odd mode.
//   - Reports the word, parity status and framing status with a one-cycle valid pulse.
//   - Sits between a bit-rate strobe generator and the consumer of checked data words.

---
 rtl/parity_frame_checker.sv | 90 +++++++++
 1 files changed

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Checks even/odd parity and the stop bit, then reports the word with a one-cycle valid pulse.
module parity_frame_checker #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    input  logic              parity_odd,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  count;
    logic              acc;
    logic              odd_mode;
    logic              perr;

    // total is the XOR of data and parity bits; the mode says which total is legal.
    function automatic logic parity_fail(input logic total, input logic odd);
        return odd ? ~total : total;
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            count       <= '0;
            acc         <= 1'b0;
            odd_mode    <= 1'b0;
            perr        <= 1'b0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!rx) begin
                            state    <= DATA;
                            odd_mode <= parity_odd;
                            count    <= '0;
                            acc      <= 1'b0;
                        end
                    end
                    DATA: begin
                        // Right shift so d0 lands in bit 0 once all bits are in.
                        shreg <= {rx, shreg[DATA_W-1:1]};
                        acc   <= acc ^ rx;
                        count <= count + 1'b1;
                        if (count == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        perr  <= parity_fail(acc ^ rx, odd_mode);
                        state <= STOP;
                    end
                    STOP: begin
                        data_out    <= shreg;
                        parity_err  <= perr;
                        frame_err   <= ~rx;
                        frame_valid <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
